// File: rtl/uart_pkg.sv
// Shared constants and types for the UART echo block.
//   DEF_CLK_FREQ / DEF_BAUD_RATE / DEF_CLKS_PER_BIT : default timing
//   DATA_BITS    : payload bits per frame (8N1)
//   uart_state_e : state encoding shared by the RX and TX sequencers
package uart_pkg;

  localparam int DEF_CLK_FREQ     = 100_000_000;
  localparam int DEF_BAUD_RATE    = 115_200;
  localparam int DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD_RATE;
  localparam int DATA_BITS        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer followed by a mid-bit sampling FSM.
//   clk, rst : system clock, synchronous active-high reset
//   rxd      : asynchronous serial input, idle high
//   rx_byte  : last received byte, valid while rx_valid is high
//   rx_valid : one-clock pulse for each correctly framed byte
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rxd_p0_q, rxd_p1_q;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 rx_valid_q, rx_valid_d;

  // Stage p0/p1: metastability synchronizer, resets to the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0_q   <= 1'b1;
      rxd_p1_q   <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rxd_p0_q   <= rxd;
      rxd_p1_q   <= rxd_p0_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_p1_q) state_d = ST_START;
      end
      ST_START: begin
        // Re-check half a bit in; a high level here was only a glitch
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxd_p1_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shreg_d = {rxd_p1_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so an immediately following start edge is seen
        if (cnt_q == CNT_BIT) begin
          cnt_d      = '0;
          rx_valid_d = rxd_p1_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_byte  = shreg_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter with registered serial output.
//   clk, rst : system clock, synchronous active-high reset
//   tx_byte  : byte to send, captured when tx_start is accepted
//   tx_start : request; accepted whenever tx_busy is low
//   txd      : serial output, idle high
//   tx_busy  : high while a frame occupies the line
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 tx_start,
  output logic                 txd,
  output logic                 tx_busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 txd_q, txd_d;
  logic                 bit_end, ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign bit_end = (cnt_q == CNT_BIT);
  // The last stop-bit clock also accepts a new byte, keeping the stop bit
  // exactly one bit period so back-to-back input does not slowly overrun.
  assign ready   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ready && tx_start) begin
      state_d = ST_START;
      cnt_d   = '0;
      shreg_d = tx_byte;
      txd_d   = 1'b0;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = !ready;

endmodule

// File: rtl/uart_top.sv
// UART echo: every correctly framed byte received on rxd is resent on txd.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   rxd  : asynchronous serial input, idle high
//   txd  : registered serial output, idle high
// Holds one byte between receiver and transmitter; a byte arriving while
// the buffer is still full and not being drained is dropped.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD_RATE    = DEF_BAUD_RATE,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd
);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_valid;
  logic                 tx_busy;
  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 take;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  assign take = full_q && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    if (take) full_d = 1'b0;
    // Load when empty, or when the transmitter drains it this very cycle
    if (rx_valid && (!full_q || take)) begin
      full_d = 1'b1;
      hold_d = rx_byte;
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_byte  (hold_q),
    .tx_start (full_q),
    .txd      (txd),
    .tx_busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top, run at a reduced bit period (16 clocks)
// so the whole plan fits in a short simulation.
module tb_uart_top;

  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 6_250_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   got_q[$];
  logic [7:0] mon_b;
  logic tx_samp [0:10*CPB-1];
  logic [7:0] seq6 [0:5] = '{8'hA5, 8'h3C, 8'h12, 8'hA5, 8'h3C, 8'h12};

  uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .txd (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Must be called on a negedge; ends on a negedge with the line idle high
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic settle();
    repeat (12*CPB) @(negedge clk);
  endtask

  function automatic int got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : -1;
  endfunction

  // Decoded echo stream: byte in [7:0], bit 8 set when the stop bit was low
  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (HALF) @(negedge clk);
        if (txd === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = txd;
          end
          repeat (CPB) @(negedge clk);
          got_q.push_back(int'({23'd0, ~txd, mon_b}));
        end
      end
    end
  end

  task automatic measure_a5();
    int         start_cyc;
    int         fall_cyc;
    int         lat;
    int         errs;
    bit         found;
    logic [9:0] frame;
    start_cyc = cyc;
    found     = 1'b0;
    for (int i = 0; i < 20*CPB && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    if (!found) begin
      check_eq("a5_start_seen", 0, 1);
      return;
    end
    fall_cyc = cyc;
    // Nominal stop-bit centre on the input side, plus synchronizer slack
    lat = fall_cyc - (start_cyc + 1 + 9*CPB + HALF);
    check_eq("a5_latency_in_0_7", int'(lat >= 0 && lat <= 7), 1);
    tx_samp[0] = txd;
    for (int j = 1; j < 10*CPB; j++) begin
      @(negedge clk);
      tx_samp[j] = txd;
    end
    frame = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int j = b*CPB + 1; j <= b*CPB + CPB - 2; j++)
        if (tx_samp[j] !== frame[b]) errs++;
      check_eq($sformatf("a5_bit%0d_bad_samples", b), errs, 0);
    end
  endtask

  initial begin
    int lows;

    repeat (5) @(negedge clk);
    check_eq("rst_txd", int'(txd), 1);
    rst = 1'b0;

    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check_eq("idle_txd_not_high", lows, 0);
    check_eq("idle_frames", got_q.size(), 0);

    fork
      send_byte(8'hA5, 1'b1);
      measure_a5();
    join
    settle();
    check_eq("a5_count", got_q.size(), 1);
    check_eq("a5_value", got_at(0), 32'hA5);
    got_q.delete();

    for (int i = 0; i < 6; i++) begin
      send_byte(seq6[i], 1'b1);
      repeat (6*CPB) @(negedge clk);
    end
    settle();
    check_eq("seq6_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("seq6_value%0d", i), got_at(i), int'(seq6[i]));
    got_q.delete();

    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    settle();
    check_eq("glitch_frames", got_q.size(), 0);
    send_byte(8'h3C, 1'b1);
    settle();
    check_eq("post_glitch_count", got_q.size(), 1);
    check_eq("post_glitch_value", got_at(0), 32'h3C);
    got_q.delete();

    send_byte(8'h12, 1'b0);
    settle();
    check_eq("framing_err_frames", got_q.size(), 0);
    send_byte(8'hA5, 1'b1);
    settle();
    check_eq("post_ferr_count", got_q.size(), 1);
    check_eq("post_ferr_value", got_at(0), 32'hA5);
    got_q.delete();

    send_byte(8'h3C, 1'b1);
    send_byte(8'h12, 1'b1);
    settle();
    check_eq("b2b_count", got_q.size(), 2);
    check_eq("b2b_value0", got_at(0), 32'h3C);
    check_eq("b2b_value1", got_at(1), 32'h12);
    got_q.delete();

    // Echo of 0x3C is in its first data bit (a 0) twenty clocks after input ends
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("pre_rst_txd", int'(txd), 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_tx_txd", int'(txd), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle();
    got_q.delete();
    check_eq("post_rst_idle_txd", int'(txd), 1);
    send_byte(8'hA5, 1'b1);
    settle();
    check_eq("post_rst_count", got_q.size(), 1);
    check_eq("post_rst_value", got_at(0), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_top.md
Name: uart_top

Overview:
- UART echo/loopback block. It receives 8N1 serial frames on rxd and retransmits each correctly framed byte unchanged on txd.
- Sits at the board/top level between the external UART pins and the 100 MHz system clock domain.
- Internally it is a receiver, a one-byte holding buffer and a transmitter.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (= 868, truncated), clocks per bit period.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- rxd  input  1  asynchronous serial input, idle high.
- txd  output 1  serial output, idle high, registered.

Behaviour:
- Reset: txd=1; RX and TX FSMs go to IDLE; bit/clock counters cleared; holding buffer empty. Asserting rst mid-frame aborts the frame, and txd is 1 on the next clock.
- Input sync: rxd passes through a 2-FF synchronizer, reset value 1. The RX logic uses only the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized rxd == 0.
  - START: wait CLKS_PER_BIT/2 (434) clocks, then resample. If the sample is 0 -> DATA; if 1 -> IDLE (glitch rejected).
  - DATA: sample every CLKS_PER_BIT clocks, i.e. at the bit centres. Shift LSB-first and collect 8 bits.
  - STOP: sample after CLKS_PER_BIT more clocks.
    - Sample 1: pulse rx_valid for one clock with rx_byte.
    - Sample 0: framing error; byte discarded, no pulse.
  - STOP always returns to IDLE immediately after the stop sample, so a start bit following at the nominal stop-bit end is caught.
- Holding buffer: one byte plus a full flag.
  - rx_valid sets full and loads the byte.
  - TX takes the byte when it is IDLE and full=1; full clears that cycle.
  - rx_valid while full is an overrun: the new byte is dropped and the buffered byte is kept.
  - rx_valid in the same cycle TX takes the buffer: the new byte is loaded and full stays 1.
- TX FSM states: IDLE, START, DATA, STOP.
  - Frame: start 0, 8 data bits LSB first, 1 stop bit.
  - Each bit is held exactly CLKS_PER_BIT clocks.
  - Back to IDLE after the stop bit completes. It can start the next byte on the following clock.
- Latency: txd falls (start bit) no more than 4 clocks after the RX stop-bit sample clock edge.
- Throughput: continuous back-to-back input frames, with zero idle between them, are echoed without loss.

Decomposition:
- Package uart_pkg holds:
  - CLK_FREQ, BAUD_RATE and CLKS_PER_BIT defaults;
  - the RX/TX state enum;
  - DATA_BITS = 8.
- Two natural sub-modules:
  - uart_rx: synchronizer + RX FSM, outputs rx_byte/rx_valid.
  - uart_tx: inputs tx_byte/tx_start, outputs txd/tx_busy.
- uart_top contains only the holding buffer and the wiring.

Test Plan:
- Reset, then rxd held at 1 for 10 us -> txd constant 1, no activity.
- Send 0xA5, bit time 8680 ns -> txd emits start 0, bits 1,0,1,0,0,1,0,1, stop 1. Each bit is 868±1 clocks wide; the start edge is ≤4 clocks after the RX stop sample.
- Send A5, 3C, 12, A5, 3C, 12, each followed by 50 us idle -> six echoed frames on txd in the same order with identical values.
- Glitch: rxd low for 200 clocks, then high -> no output frame; a following 0x3C is echoed correctly.
- Framing error: send 0x12 with stop bit 0, then rxd high -> no echo. The next valid 0xA5 is echoed.
- Back-to-back 0x3C, 0x12 with no idle gap -> both echoed in order. Assert rst mid-TX of a second run -> txd=1 next cycle, and the block resumes echoing after release.
